video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Pixel-clock raster timing generator; sits directly upstream of the image controller.
- Drives the cx/cy raster coordinates the image controller consumes, and takes back its 24-bit rgb.
- Emits display-ready rgb/hsync/vsync/de with the control signals delayed to line up with the rgb return latency.
- Also provides a frame-start pulse and a frame counter for the time controller.

Parameters:
- FRAME_WIDTH, 2200, total pixels per line including blanking
- FRAME_HEIGHT, 1125, total lines per frame including blanking
- SCREEN_WIDTH, 1920, active pixels per line
- SCREEN_HEIGHT, 1080, active lines per frame
- H_FRONT, 88, horizontal front porch in pixels
- H_SYNC, 44, hsync width in pixels
- V_FRONT, 4, vertical front porch in lines
- V_SYNC, 5, vsync width in lines
- BIT_WIDTH, 12, cx width
- BIT_HEIGHT, 11, cy width
- RGB_LATENCY, 2, cycles from cx/cy presented to matching rgb_in valid (range 0..15)
- SYNC_ACTIVE_HIGH, 1, sync polarity (1 = asserted high)

Ports:
- clk_pixel  in  1  pixel clock
- clk_pixel_resetn  in  1  asynchronous active-low reset
- enable  in  1  run raster; low = hold at origin and blank
- cx  out  BIT_WIDTH  current x coordinate, registered
- cy  out  BIT_HEIGHT  current y coordinate, registered
- rgb_in  in  24  pixel for coordinates presented RGB_LATENCY cycles earlier
- pattern_sel  in  1  select test pattern (used only with the optional feature)
- out_rgb  out  24  display pixel, 0 outside active area
- out_hsync  out  1  aligned hsync
- out_vsync  out  1  aligned vsync
- out_de  out  1  aligned data enable
- frame_start  out  1  one-cycle pulse, aligned with the cx=0,cy=0 output
- frame_count  out  32  completed frames since reset

Behaviour:
- Reset (async assert, sync release) values:
  - cx=0, cy=0, out_rgb=0, out_de=0, frame_start=0, frame_count=0.
  - out_hsync/out_vsync at their inactive level (0 if SYNC_ACTIVE_HIGH, else 1).
  - Delay line cleared to the blank/inactive state.
- Raster counters:
  - While enable=1, cx increments every cycle.
  - At cx==FRAME_WIDTH-1: cx wraps to 0 and cy increments.
  - At cx==FRAME_WIDTH-1 and cy==FRAME_HEIGHT-1: both wrap to 0 and frame_count increments (modulo 2^32).
- enable=0 (including mid-frame):
  - Next cycle cx=cy=0 and counters hold.
  - Timing inputs to the delay line are forced blank (de=0, syncs inactive).
  - The delay line keeps shifting, so outputs go blank within RGB_LATENCY+1 cycles.
  - frame_count is not incremented by an aborted frame.
- enable rising: the first cycle with enable=1 presents cx=0,cy=0 with frame_start qualifier set.
- Raw timing, from the currently presented cx/cy:
  - de = (cx<SCREEN_WIDTH)&&(cy<SCREEN_HEIGHT).
  - hsync active for SCREEN_WIDTH+H_FRONT <= cx < SCREEN_WIDTH+H_FRONT+H_SYNC.
  - vsync active for SCREEN_HEIGHT+V_FRONT <= cy < SCREEN_HEIGHT+V_FRONT+V_SYNC; full lines, changes on the cx=0 boundary.
  - fs = enable && cx==0 && cy==0.
- Alignment:
  - {de, hsync, vsync, fs} pass through an RGB_LATENCY-deep shift register.
  - Output register: out_rgb = de_d ? rgb_in : 0; out_de = de_d; syncs and frame_start take the delayed values.
  - Total latency from cx/cy presentation to the out_* signals is RGB_LATENCY+1 cycles.
  - With RGB_LATENCY=0 only the output register remains.
- Width rules:
  - Comparisons are unsigned.
  - Sync window bounds are computed in a width one bit larger than BIT_WIDTH/BIT_HEIGHT to avoid overflow.
- Elaboration-time checks: SCREEN_* < FRAME_*; porch+sync fits in blanking; FRAME_WIDTH <= 2^BIT_WIDTH.

Optional Feature:
- Macro: VIDEO_TIMING_TEST_PATTERN_EN.
- Defined:
  - When pattern_sel=1, rgb_in is ignored.
  - Colour-bar value is computed from cx at presentation time and delayed through the same shift register.
  - Eight vertical bars, each SCREEN_WIDTH/8 wide: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Blanking still forces 0.
- Not defined: pattern_sel is ignored, no pattern logic is synthesised, and out_rgb always derives from rgb_in.

Decomposition:
- Package video_timing_pkg holds:
  - 1080p60 default timing constants.
  - typedef struct packed {de, hsync, vsync, fs} timing_t.
  - Colour-bar lookup constant array.
- One sub-module: timing_delay_line, a parameterised depth/width shift register with async active-low reset to a parameterised reset value, instantiated for timing_t (plus 24-bit pattern data when the feature is enabled).

Test Plan:
- Reset then enable=1, RGB_LATENCY=2, rgb_in = {cy[7:0],cx[11:0],4'h0} model -> out_de first high 3 cycles after cx=0,cy=0; out_rgb=000000 at (0,0); out_rgb matches the model at (1919,1079); out_rgb=0 at cx=1920.
- Count a full line -> cx wraps 2199->0 with cy +1; out_hsync active for exactly 44 cycles starting at the output of cx=2008.
- Run 2 full frames (2200*1125 cycles each) -> frame_count=2; frame_start pulses exactly twice, 2,475,000 cycles apart; out_vsync active for 5 lines starting at line 1084.
- Drop enable at cx=500,cy=300 -> next cycle cx=cy=0; out_de=0 within 3 cycles; frame_count unchanged; re-enable restarts at (0,0) with frame_start.
- Assert clk_pixel_resetn low mid-line -> all outputs at reset values immediately without a clock edge; frame_count=0 after release.
- With VIDEO_TIMING_TEST_PATTERN_EN and pattern_sel=1 -> out_rgb=FFFFFF for cx 0..239, FFFF00 for 240..479, 000000 for 1680..1919, 0 in blanking.

Source files
------------

// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 1080p60 default timing, delay-line payload type and colour-bar table.
package video_timing_pkg;
  localparam int FRAME_WIDTH_1080P = 2200;
  localparam int FRAME_HEIGHT_1080P = 1125;
  localparam int SCREEN_WIDTH_1080P = 1920;
  localparam int SCREEN_HEIGHT_1080P = 1080;
  localparam int H_FRONT_1080P = 88;
  localparam int H_SYNC_1080P = 44;
  localparam int V_FRONT_1080P = 4;
  localparam int V_SYNC_1080P = 5;
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic fs;
  } timing_t;
  // Entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_RGB = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                          24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    return BAR_RGB[idx];
  endfunction
endpackage

// File: rtl/timing_delay_line.sv
// timing_delay_line: DEPTH-stage shift register with async reset to RST_VAL; DEPTH=0 is a wire.
module timing_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk | rst_n;
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr_q [DEPTH];
    logic [WIDTH-1:0] sr_d [DEPTH];
    always_comb begin
      sr_d[0] = d;
      for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      else sr_q <= sr_d;
    end
    assign q = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters plus sync/de/frame-start aligned to the rgb return latency.
// Define VIDEO_TIMING_TEST_PATTERN_EN to add the pattern_sel colour-bar source.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int FRAME_WIDTH = FRAME_WIDTH_1080P,
  parameter int FRAME_HEIGHT = FRAME_HEIGHT_1080P,
  parameter int SCREEN_WIDTH = SCREEN_WIDTH_1080P,
  parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_1080P,
  parameter int H_FRONT = H_FRONT_1080P,
  parameter int H_SYNC = H_SYNC_1080P,
  parameter int V_FRONT = V_FRONT_1080P,
  parameter int V_SYNC = V_SYNC_1080P,
  parameter int BIT_WIDTH = 12,
  parameter int BIT_HEIGHT = 11,
  parameter int RGB_LATENCY = 2,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk_pixel,
  input  logic                  clk_pixel_resetn,
  input  logic                  enable,
  output logic [BIT_WIDTH-1:0]  cx,
  output logic [BIT_HEIGHT-1:0] cy,
  input  logic [23:0]           rgb_in,
  input  logic                  pattern_sel,
  output logic [23:0]           out_rgb,
  output logic                  out_hsync,
  output logic                  out_vsync,
  output logic                  out_de,
  output logic                  frame_start,
  output logic [31:0]           frame_count
);
  localparam int XW = BIT_WIDTH + 1;
  localparam int YW = BIT_HEIGHT + 1;
  localparam logic SYNC_OFF = !SYNC_ACTIVE_HIGH;
  localparam logic [BIT_WIDTH-1:0] X_LAST = BIT_WIDTH'(FRAME_WIDTH - 1);
  localparam logic [BIT_HEIGHT-1:0] Y_LAST = BIT_HEIGHT'(FRAME_HEIGHT - 1);
  localparam logic [BIT_WIDTH-1:0] X_ACT = BIT_WIDTH'(SCREEN_WIDTH);
  localparam logic [BIT_HEIGHT-1:0] Y_ACT = BIT_HEIGHT'(SCREEN_HEIGHT);
  localparam logic [XW-1:0] HS_START = XW'(SCREEN_WIDTH + H_FRONT);
  localparam logic [XW-1:0] HS_END = XW'(SCREEN_WIDTH + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] VS_START = YW'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [YW-1:0] VS_END = YW'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
  if (SCREEN_WIDTH >= FRAME_WIDTH || SCREEN_HEIGHT >= FRAME_HEIGHT ||
      H_FRONT + H_SYNC > FRAME_WIDTH - SCREEN_WIDTH || V_FRONT + V_SYNC > FRAME_HEIGHT - SCREEN_HEIGHT ||
      FRAME_WIDTH > (1 << BIT_WIDTH) || FRAME_HEIGHT > (1 << BIT_HEIGHT) ||
      RGB_LATENCY < 0 || RGB_LATENCY > 15) begin : g_bad_cfg
    $error("video_timing_gen: inconsistent timing parameters");
  end
  logic [BIT_WIDTH-1:0] cx_q, cx_d;
  logic [BIT_HEIGHT-1:0] cy_q, cy_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [23:0] out_rgb_q, out_rgb_d, pix;
  logic out_hsync_q, out_hsync_d, out_vsync_q, out_vsync_d;
  logic out_de_q, out_de_d, frame_start_q, frame_start_d;
  logic x_last, y_last;
  timing_t raw, dly;
  always_comb begin
    x_last = cx_q == X_LAST;
    y_last = cy_q == Y_LAST;
    cx_d = (!enable || x_last) ? '0 : cx_q + 1'b1;
    cy_d = !enable ? '0 : x_last ? (y_last ? '0 : cy_q + 1'b1) : cy_q;
    frame_count_d = frame_count_q + {31'd0, enable && x_last && y_last};
    // Disabled raster feeds blank timing so the pipeline drains to blank.
    raw = '{de:    enable && cx_q < X_ACT && cy_q < Y_ACT,
            hsync: enable && {1'b0, cx_q} >= HS_START && {1'b0, cx_q} < HS_END,
            vsync: enable && {1'b0, cy_q} >= VS_START && {1'b0, cy_q} < VS_END,
            fs:    enable && cx_q == '0 && cy_q == '0};
  end
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  localparam int BAR_W = SCREEN_WIDTH >= 8 ? SCREEN_WIDTH / 8 : 1;
  localparam int DLW = $bits(timing_t) + 24;
  logic [BIT_WIDTH-1:0] bar_idx;
  logic [23:0] bar_raw, bar_dly;
  logic [DLW-1:0] dl_d, dl_q;
  always_comb begin
    bar_idx = cx_q / BIT_WIDTH'(BAR_W);
    bar_raw = bar_color(bar_idx > 7 ? 3'd7 : bar_idx[2:0]);
  end
  assign dl_d = {raw, bar_raw};
  assign {dly, bar_dly} = dl_q;
  assign pix = pattern_sel ? bar_dly : rgb_in;
`else
  localparam int DLW = $bits(timing_t);
  logic [DLW-1:0] dl_d, dl_q;
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign dl_d = raw;
  assign dly = dl_q;
  assign pix = rgb_in;
`endif
  timing_delay_line #(.DEPTH(RGB_LATENCY), .WIDTH(DLW), .RST_VAL('0)) u_dly (
    .clk(clk_pixel), .rst_n(clk_pixel_resetn), .d(dl_d), .q(dl_q)
  );
  always_comb begin
    out_rgb_d = dly.de ? pix : '0;
    out_de_d = dly.de;
    out_hsync_d = dly.hsync ^ SYNC_OFF;
    out_vsync_d = dly.vsync ^ SYNC_OFF;
    frame_start_d = dly.fs;
  end
  always_ff @(posedge clk_pixel or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      cx_q <= '0;
      cy_q <= '0;
      frame_count_q <= '0;
      out_rgb_q <= '0;
      out_de_q <= 1'b0;
      out_hsync_q <= SYNC_OFF;
      out_vsync_q <= SYNC_OFF;
      frame_start_q <= 1'b0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
      frame_count_q <= frame_count_d;
      out_rgb_q <= out_rgb_d;
      out_de_q <= out_de_d;
      out_hsync_q <= out_hsync_d;
      out_vsync_q <= out_vsync_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign cx = cx_q;
  assign cy = cy_q;
  assign frame_count = frame_count_q;
  assign out_rgb = out_rgb_q;
  assign out_de = out_de_q;
  assign out_hsync = out_hsync_q;
  assign out_vsync = out_vsync_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: random enable/reset stimulus on a reduced raster against a linear-index model.
module tb_video_timing_gen;
  localparam int FW = 40, FH = 20, SW = 32, SH = 16, HF = 2, HS = 3, VF = 1, VS = 2;
  localparam int BW = 6, BH = 5, LAT = 2;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pattern_sel = 1'b0;
  logic [23:0] rgb_in = '0;
  logic [BW-1:0] cx;
  logic [BH-1:0] cy;
  logic [23:0] out_rgb;
  logic out_hsync, out_vsync, out_de, frame_start;
  logic [31:0] frame_count;
  int checks = 0, failures = 0;
  typedef struct {bit de; bit hs; bit vs; bit fs; int x; int y;} ent_t;
  ent_t q[$];
  int m_pos = 0, m_fc = 0;
  logic [23:0] exp_rgb = '0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  bit e_r, ps_r;
  int first_de, fs_n, fs_at, fs_gap, hs_run, hs_cyc, vs_cyc, fc_save;

  always #5 clk = ~clk;

  video_timing_gen #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH),
    .H_FRONT(HF), .H_SYNC(HS), .V_FRONT(VF), .V_SYNC(VS),
    .BIT_WIDTH(BW), .BIT_HEIGHT(BH), .RGB_LATENCY(LAT), .SYNC_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk_pixel(clk), .clk_pixel_resetn(rst_n), .enable(enable), .cx(cx), .cy(cy),
    .rgb_in(rgb_in), .pattern_sel(pattern_sel), .out_rgb(out_rgb), .out_hsync(out_hsync),
    .out_vsync(out_vsync), .out_de(out_de), .frame_start(frame_start), .frame_count(frame_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] pixel(input int x, input int y);
    return {y[7:0], x[11:0], 4'h0};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_cx"}, 32'(cx), 0);
    check({tag, "_cy"}, 32'(cy), 0);
    check({tag, "_rgb"}, 32'(out_rgb), 0);
    check({tag, "_de"}, 32'(out_de), 0);
    check({tag, "_hs"}, 32'(out_hsync), 0);
    check({tag, "_vs"}, 32'(out_vsync), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_fc"}, frame_count, 0);
  endtask

  task automatic model_clear();
    q.delete();
    m_pos = 0;
    m_fc = 0;
    exp_rgb = '0;
  endtask

  // One pixel clock: compare at the falling edge, then drive the next inputs.
  task automatic step(input bit e, input bit ps);
    ent_t r, h;
    @(negedge clk);
    h = '{default: 0};
    if (q.size() == LAT + 1) h = q[0];
    check("cx", 32'(cx), m_pos % FW);
    check("cy", 32'(cy), m_pos / FW);
    check("frame_count", frame_count, m_fc);
    check("out_de", 32'(out_de), 32'(h.de));
    check("out_hsync", 32'(out_hsync), 32'(h.hs));
    check("out_vsync", 32'(out_vsync), 32'(h.vs));
    check("frame_start", 32'(frame_start), 32'(h.fs));
    check("out_rgb", 32'(out_rgb), 32'(exp_rgb));
    enable = e;
    pattern_sel = ps;
    r.x = m_pos % FW;
    r.y = m_pos / FW;
    r.de = e && r.x < SW && r.y < SH;
    r.hs = e && r.x >= SW + HF && r.x < SW + HF + HS;
    r.vs = e && r.y >= SH + VF && r.y < SH + VF + VS;
    r.fs = e && m_pos == 0;
    q.push_back(r);
    if (q.size() > LAT + 1) void'(q.pop_front());
    rgb_in = 24'($urandom);
    exp_rgb = '0;
    if (q.size() == LAT + 1 && q[0].de) begin
      rgb_in = pixel(q[0].x, q[0].y);
      exp_rgb = ps ? bars[q[0].x / (SW / 8)] : rgb_in;
    end
    m_pos = !e ? 0 : (m_pos + 1) % (FW * FH);
    if (e && m_pos == 0) m_fc++;
  endtask

  initial begin
    #2 check_reset("rst0");
    #10 rst_n = 1'b1;
    model_clear();
    first_de = -1; fs_n = 0; fs_at = 0; fs_gap = 0; hs_run = 0; hs_cyc = 0; vs_cyc = 0;
    for (int i = 0; i < 2 * FW * FH; i++) begin
      step(1'b1, 1'b0);
      if (out_de && first_de < 0) first_de = i;
      if (frame_start) begin
        if (fs_n == 1) fs_gap = i - fs_at;
        fs_at = i;
        fs_n++;
      end
      if (out_hsync) hs_cyc++;
      if (out_vsync) vs_cyc++;
      if (out_hsync) hs_run++;
      else if (hs_run > 0) begin
        check("hs_run", hs_run, HS);
        hs_run = 0;
      end
    end
    check("first_de", first_de, LAT + 1);
    check("fs_pulses", fs_n, 2);
    check("fs_gap", fs_gap, FW * FH);
    check("hs_cycles", hs_cyc, 2 * FH * HS);
    check("vs_cycles", vs_cyc, 2 * VS * FW);
    @(posedge clk);
    #1 check("fc_2frames", frame_count, 2);
    for (int i = 0; i < FW * FH && m_pos != 10 * FW + 20; i++) step(1'b1, 1'b0);
    fc_save = m_fc;
    step(1'b0, 1'b0);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 1'b0);
    check("drop_de", 32'(out_de), 0);
    check("drop_fc", frame_count, fc_save);
    for (int i = 0; i < 3000; i++) begin
      e_r = $urandom_range(0, 399) != 0;
      ps_r = 1'b0;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
      ps_r = $urandom_range(0, 1) == 1;
`endif
      step(e_r, ps_r);
    end
    for (int i = 0; i < 17 + $urandom_range(0, 15); i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("fc_after_rst", frame_count, 0);
    model_clear();
    for (int i = 0; i < FW * FH + 50; i++) step(1'b1, 1'b0);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < FW * FH + 10; i++) step(1'b1, 1'b1);
`endif
    step(1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
